// File: rtl/pixel_array_ctrl_if.sv
// Result stream leaving pixel_array_ctrl: one captured pixel per beat, tagged with index and last.
// A beat transfers on a rising edge with out_valid && out_ready; until then the master keeps out_valid high and out_data/out_index/out_last unchanged.
interface pixel_array_ctrl_if #(
  parameter int W  = 8,
  parameter int SW = 2
);
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, out_index, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_index, out_valid, out_last, output out_ready);
endinterface

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for pixel_array: clear, erase, optional CDS reference, expose, convert,
// then per-pixel select/capture with each result streamed out on a valid/ready port.
module pixel_array_ctrl #(
  parameter int PIXEL_COUNT    = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int ERASE_CYCLES   = 4,
  parameter int CONVERT_CYCLES = 255,
  parameter int EXPT_WIDTH     = 16,
  localparam int SW = $clog2(PIXEL_COUNT),
  localparam int W  = COUNTER_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cds_en,
  input  logic [EXPT_WIDTH-1:0] expose_time,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  arr_reset,
  output logic                  arr_erase,
  output logic                  arr_corr,
  output logic                  arr_expose,
  output logic                  arr_convert,
  output logic                  arr_read,
  output logic                  arr_cds,
  output logic [SW-1:0]         arr_sel,
  input  logic [W-1:0]          arr_pixel,
  pixel_array_ctrl_if.master    stream,
  output logic [3:0]            dbg_state
);
  localparam int CONV_BITS = $clog2(CONVERT_CYCLES + 1);
  localparam int CW = (EXPT_WIDTH > CONV_BITS) ? EXPT_WIDTH : CONV_BITS;

  typedef enum logic [3:0] {
    IDLE, CLR, ERASE, CORR, EXPOSE, CLR2, CONVERT, RD_SET, RD_CAP, RD_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_load;
  logic [SW-1:0]         idx_q;
  logic                  cds_q;
  logic [EXPT_WIDTH-1:0] exp_q;
  logic                  start_acc, accept, last_pix, cnt_done;
  logic                  reset_d, erase_d, corr_d, expose_d, convert_d, read_d;
  logic                  busy_d, done_d, cds_d;

  // frame_done is high only in IDLE, so gating on it drops a start in the done cycle.
  assign start_acc = (state_q == IDLE) && start && !frame_done;
  assign accept    = (state_q == RD_WAIT) && stream.out_ready;
  assign last_pix  = (idx_q == SW'(PIXEL_COUNT - 1));
  assign cnt_done  = (cnt_q == CW'(1));
  assign dbg_state = state_q;
  assign arr_sel   = idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = CLR;
      CLR:     state_d = ERASE;
      ERASE:   if (cnt_done) state_d = cds_q ? CORR : EXPOSE;
      CORR:    state_d = EXPOSE;
      EXPOSE:  if (cnt_done) state_d = CLR2;
      CLR2:    state_d = CONVERT;
      CONVERT: if (cnt_done) state_d = RD_SET;
      RD_SET:  state_d = RD_CAP;
      RD_CAP:  state_d = RD_WAIT;
      RD_WAIT: if (accept) state_d = last_pix ? IDLE : RD_SET;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    reset_d   = (state_d == CLR) || (state_d == CLR2);
    erase_d   = (state_d == ERASE);
    corr_d    = (state_d == CORR);
    expose_d  = (state_d == EXPOSE);
    convert_d = (state_d == CONVERT);
    read_d    = (state_d == RD_SET) || (state_d == RD_CAP);
    busy_d    = (state_d != IDLE);
    done_d    = accept && last_pix;
    cds_d     = busy_d && (start_acc ? cds_en : cds_q);
    case (state_d)
      ERASE:   cnt_load = CW'(ERASE_CYCLES);
      EXPOSE:  cnt_load = CW'(exp_q);
      CONVERT: cnt_load = CW'(CONVERT_CYCLES);
      default: cnt_load = CW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q            <= '0;
      idx_q            <= '0;
      cds_q            <= 1'b0;
      exp_q            <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      arr_reset        <= 1'b0;
      arr_erase        <= 1'b0;
      arr_corr         <= 1'b0;
      arr_expose       <= 1'b0;
      arr_convert      <= 1'b0;
      arr_read         <= 1'b0;
      arr_cds          <= 1'b0;
      stream.out_data  <= '0;
      stream.out_index <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
    end else begin
      if (start_acc) begin
        cds_q <= cds_en;
        exp_q <= (expose_time == '0) ? EXPT_WIDTH'(1) : expose_time;
      end
      // Counter reloads on every state change and parks at 1 rather than wrapping.
      if (state_d != state_q)  cnt_q <= cnt_load;
      else if (cnt_q > CW'(1)) cnt_q <= cnt_q - CW'(1);
      if (accept) idx_q <= last_pix ? '0 : idx_q + SW'(1);
      busy        <= busy_d;
      frame_done  <= done_d;
      arr_reset   <= reset_d;
      arr_erase   <= erase_d;
      arr_corr    <= corr_d;
      arr_expose  <= expose_d;
      arr_convert <= convert_d;
      arr_read    <= read_d;
      arr_cds     <= cds_d;
      if (state_q == RD_CAP) begin
        stream.out_data  <= arr_pixel;
        stream.out_index <= idx_q;
        stream.out_valid <= 1'b1;
        stream.out_last  <= last_pix;
      end else if (accept) begin
        stream.out_valid <= 1'b0;
        stream.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl: each frame is expanded from its phase durations into a per-cycle
// expected trace (which also carries the start/out_ready stimulus) and checked every cycle.
module tb_pixel_array_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cds_en;
  logic [15:0] expose_time;
  logic        busy, frame_done, arr_reset, arr_erase, arr_corr, arr_expose;
  logic        arr_convert, arr_read, arr_cds;
  logic [1:0]  arr_sel;
  logic [7:0]  arr_pixel;
  logic [3:0]  dbg_state;
  logic [7:0]  pix_val [4];

  int n_cmp = 0;
  int n_bad = 0;

  pixel_array_ctrl_if #(.W(8), .SW(2)) st ();

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cds_en(cds_en), .expose_time(expose_time),
    .busy(busy), .frame_done(frame_done), .arr_reset(arr_reset), .arr_erase(arr_erase),
    .arr_corr(arr_corr), .arr_expose(arr_expose), .arr_convert(arr_convert),
    .arr_read(arr_read), .arr_cds(arr_cds), .arr_sel(arr_sel), .arr_pixel(arr_pixel),
    .stream(st), .dbg_state(dbg_state)
  );

  // Array stand-in: the selected pixel's value.
  assign arr_pixel = pix_val[arr_sel];

  always #5 clk = ~clk;

  localparam logic [5:0] C_RST = 6'b100000, C_ERASE = 6'b010000, C_CORR = 6'b001000;
  localparam logic [5:0] C_EXP = 6'b000100, C_CONV  = 6'b000010, C_READ = 6'b000001;

  typedef struct packed {
    logic       stim_start;
    logic       stim_rdy;
    logic       busy;
    logic       done;
    logic [5:0] ctl;
    logic       cds;
    logic [1:0] sel;
    logic       valid;
    logic       last;
    logic [1:0] index;
    logic [7:0] data;
  } rec_t;
  localparam int RW = $bits(rec_t);
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r = '0;
    r.stim_rdy = 1'b1;
    return r;
  endfunction

  function automatic rec_t phase_rec(input logic [5:0] ctl, input logic cds, input logic [1:0] sel);
    rec_t r = idle_rec();
    r.busy = 1'b1;
    r.ctl  = ctl;
    r.cds  = cds;
    r.sel  = sel;
    return r;
  endfunction

  task automatic emit(input logic [5:0] ctl, input int n, input logic cds);
    for (int i = 0; i < n; i++) exp_q.push_back(phase_rec(ctl, cds, 2'd0));
  endtask

  // Expected trace of one frame, starting with the cycle in which start is driven.
  task automatic run_frame(input logic cds, input int t_req, input int stall_idx, input int stall_len,
                           input int start_in_expose, input logic start_at_done, input int conv_cut);
    int   t;
    int   waits;
    rec_t r;
    cds_en      = cds;
    expose_time = 16'(t_req);
    t = (t_req == 0) ? 1 : t_req;
    r = idle_rec();
    r.stim_start = 1'b1;
    exp_q.push_back(r);
    emit(C_RST, 1, cds);
    emit(C_ERASE, 4, cds);
    if (cds) emit(C_CORR, 1, cds);
    for (int i = 0; i < t; i++) begin
      r = phase_rec(C_EXP, cds, 2'd0);
      r.stim_start = (i == start_in_expose);
      exp_q.push_back(r);
    end
    emit(C_RST, 1, cds);
    if (conv_cut > 0) begin
      emit(C_CONV, conv_cut, cds);
      return;
    end
    emit(C_CONV, 255, cds);
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(phase_rec(C_READ, cds, 2'(p)));
      exp_q.push_back(phase_rec(C_READ, cds, 2'(p)));
      waits = (p == stall_idx) ? stall_len : 0;
      for (int w = 0; w <= waits; w++) begin
        r = phase_rec(6'b0, cds, 2'(p));
        r.valid    = 1'b1;
        r.index    = 2'(p);
        r.last     = (p == 3);
        r.data     = pix_val[p];
        r.stim_rdy = (w == waits);
        exp_q.push_back(r);
      end
    end
    r = idle_rec();
    r.done       = 1'b1;
    r.stim_start = start_at_done;
    exp_q.push_back(r);
    for (int i = 0; i < 3; i++) exp_q.push_back(idle_rec());
  endtask

  // 0: busy cycles, 1: position of the done cycle, 2: cds cycles, 3: valid cycles, else ctl mask hits.
  function automatic int q_stat(input int what, input logic [5:0] mask);
    int   n = 0;
    rec_t r;
    for (int i = 0; i < exp_q.size(); i++) begin
      r = rec_t'(exp_q[i]);
      case (what)
        0: n += int'(r.busy);
        1: if (r.done) n = i;
        2: n += int'(r.cds);
        3: n += int'(r.valid);
        default: n += int'((r.ctl & mask) != 6'b0);
      endcase
    end
    return n;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  // Compare process: one expected record per cycle (idle when nothing is queued).
  initial begin
    rec_t r;
    start        = 1'b0;
    st.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) r = rec_t'(exp_q.pop_front());
      else                  r = idle_rec();
      check("ctl", {26'd0, arr_reset, arr_erase, arr_corr, arr_expose, arr_convert, arr_read}, 32'(r.ctl));
      check("busy", 32'(busy), 32'(r.busy));
      check("frame_done", 32'(frame_done), 32'(r.done));
      check("arr_cds", 32'(arr_cds), 32'(r.cds));
      check("arr_sel", 32'(arr_sel), 32'(r.sel));
      check("out_valid", 32'(st.out_valid), 32'(r.valid));
      check("out_last", 32'(st.out_last), 32'(r.last));
      if (r.valid) begin
        check("out_index", 32'(st.out_index), 32'(r.index));
        check("out_data", 32'(st.out_data), 32'(r.data));
      end
      start        = r.stim_start;
      st.out_ready = r.stim_rdy;
    end
  end

  initial begin
    reset       = 1'b0;
    cds_en      = 1'b0;
    expose_time = 16'd0;
    pix_val     = '{8'h11, 8'h5a, 8'ha5, 8'hff};
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Plain frame: erase 4, expose 10, convert 255, done at 2+4+10+1+255+12.
    run_frame(1'b0, 10, -1, 0, -1, 1'b0, 0);
    check("model_latency", 32'(q_stat(1, 6'b0)), 32'd284);
    check("model_busy_cycles", 32'(q_stat(0, 6'b0)), 32'd283);
    check("model_erase_cycles", 32'(q_stat(4, C_ERASE)), 32'd4);
    check("model_convert_cycles", 32'(q_stat(4, C_CONV)), 32'd255);
    wait_drain(2000);

    // CDS frame: one corr cycle, cds high for the whole busy period.
    pix_val = '{8'h00, 8'h80, 8'h7f, 8'h01};
    run_frame(1'b1, 10, -1, 0, -1, 1'b0, 0);
    check("model_corr_cycles", 32'(q_stat(4, C_CORR)), 32'd1);
    check("model_cds_cycles", 32'(q_stat(2, 6'b0)), 32'd284);
    wait_drain(2000);

    // Zero exposure behaves as one cycle.
    pix_val = '{8'h3c, 8'hc3, 8'h0f, 8'hf0};
    run_frame(1'b0, 0, -1, 0, -1, 1'b0, 0);
    check("model_expose_zero", 32'(q_stat(4, C_EXP)), 32'd1);
    wait_drain(2000);

    // Backpressure: ready low 7 cycles while index 2 is offered.
    pix_val = '{8'h21, 8'h43, 8'h65, 8'h87};
    run_frame(1'b0, 5, 2, 7, -1, 1'b0, 0);
    check("model_valid_cycles", 32'(q_stat(3, 6'b0)), 32'd11);
    wait_drain(2000);

    // Reset 100 cycles into convert: outputs clear without a clock edge.
    run_frame(1'b1, 3, -1, 0, -1, 1'b0, 100);
    wait_drain(2000);
    check("pre_reset_convert", 32'(arr_convert), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {19'd0, busy, frame_done, arr_reset, arr_erase, arr_corr, arr_expose,
          arr_convert, arr_read, arr_cds, arr_sel, st.out_valid, st.out_last}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Fresh frame after reset; starts during expose and in the done cycle are ignored.
    pix_val = '{8'h9e, 8'h2b, 8'hd4, 8'h6c};
    run_frame(1'b0, 3, -1, 0, 1, 1'b1, 0);
    wait_drain(2000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
